// File: rtl/bin2bcd_disp_pkg.sv
// Shared display codes and FSM encoding for the bin2bcd_disp converter.
package bin2bcd_disp_pkg;
  localparam logic [3:0] CODE_OFF  = 4'hA;
  localparam logic [3:0] CODE_DASH = 4'hB;
  localparam logic [3:0] CODE_H    = 4'hC;
  localparam logic [3:0] CODE_L    = 4'hD;
  localparam logic [3:0] CODE_E    = 4'hE;
  localparam logic [3:0] CODE_P    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_e;
endpackage

// File: rtl/bin2bcd_disp_dd_digit.sv
// Single-nibble add-3 correction used before each double-dabble shift.
module dd_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_disp.sv
// Sequential shift/add-3 binary to display-code converter with zero blanking.
// Optional two's complement input with a leading dash: define SIGNED_DISP_EN.
import bin2bcd_disp_pkg::*;

module bin2bcd_disp #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     en_out
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e              state_q;
  logic [WIDTH-1:0]    bin_q, mag_d;
  logic [4*DIGITS-1:0] bcd_q, corr_d, fmt_d;
  logic [CW-1:0]       cnt_q;
  logic                ovf_acc_q, fmt_ovf_d;
  int                  msd_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dd
    dd_digit u_dd (.d_i(bcd_q[4*g +: 4]), .d_o(corr_d[4*g +: 4]));
  end

`ifdef SIGNED_DISP_EN
  logic neg_q, neg_d;
  // Negating at capture keeps the shift phase identical to the unsigned build.
  assign neg_d = bin[WIDTH-1];
  assign mag_d = neg_d ? (~bin + 1'b1) : bin;
`else
  assign mag_d = bin;
`endif

  always_comb begin
    fmt_d     = '0;
    msd_d     = 0;
    fmt_ovf_d = ovf_acc_q;
    for (int i = 1; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] != 4'd0) msd_d = i;
    for (int i = 0; i < DIGITS; i++)
      fmt_d[4*i +: 4] = (i <= msd_d) ? bcd_q[4*i +: 4] : CODE_OFF;
`ifdef SIGNED_DISP_EN
    if (neg_q) begin
      if (msd_d == DIGITS - 1) fmt_ovf_d = 1'b1;
      else
        for (int i = 1; i < DIGITS; i++)
          if (i == msd_d + 1) fmt_d[4*i +: 4] = CODE_DASH;
    end
`endif
    if (fmt_ovf_d) fmt_d = {DIGITS{CODE_DASH}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      bcd_out   <= {DIGITS{CODE_OFF}};
      en_out    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
`ifdef SIGNED_DISP_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          bin_q     <= mag_d;
          bcd_q     <= '0;
          cnt_q     <= '0;
          ovf_acc_q <= 1'b0;
          busy      <= 1'b1;
          state_q   <= ST_SHIFT;
`ifdef SIGNED_DISP_EN
          neg_q     <= neg_d;
`endif
        end
        ST_SHIFT: begin
          // A 1 leaving the top nibble means the value exceeds DIGITS decimal digits.
          bcd_q     <= {corr_d[4*DIGITS-2:0], bin_q[WIDTH-1]};
          bin_q     <= {bin_q[WIDTH-2:0], 1'b0};
          ovf_acc_q <= ovf_acc_q | corr_d[4*DIGITS-1];
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_FORMAT;
        end
        ST_FORMAT: begin
          bcd_out <= fmt_d;
          ovf     <= fmt_ovf_d;
          en_out  <= '1;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_disp.sv
// Directed bench for bin2bcd_disp: 4-digit main instance plus 2- and 3-digit instances.
module tb_bin2bcd_disp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st4 = 1'b0, st2 = 1'b0, st3 = 1'b0;
  logic [9:0] bin4 = '0, bin2 = '0, bin3 = '0;
  logic busy4, done4, ovf4, busy2, done2, ovf2, busy3, done3, ovf3;
  logic [15:0] bcd4;
  logic [7:0]  bcd2;
  logic [11:0] bcd3;
  logic [3:0]  en4;
  logic [1:0]  en2;
  logic [2:0]  en3;
  int nvec = 0, nerr = 0, lat, ndone;

  always #5 clk = ~clk;

  bin2bcd_disp #(.WIDTH(10), .DIGITS(4)) u4 (.clk(clk), .rst(rst), .start(st4), .bin(bin4),
    .busy(busy4), .done(done4), .ovf(ovf4), .bcd_out(bcd4), .en_out(en4));
  bin2bcd_disp #(.WIDTH(10), .DIGITS(2)) u2 (.clk(clk), .rst(rst), .start(st2), .bin(bin2),
    .busy(busy2), .done(done2), .ovf(ovf2), .bcd_out(bcd2), .en_out(en2));
  bin2bcd_disp #(.WIDTH(10), .DIGITS(3)) u3 (.clk(clk), .rst(rst), .start(st3), .bin(bin3),
    .busy(busy3), .done(done3), .ovf(ovf3), .bcd_out(bcd3), .en_out(en3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise start now (just after an edge), return latency in edges to done.
  task automatic go(input int which, input logic [9:0] v, output int l);
    l = 0;
    case (which)
      2:       begin st2 = 1'b1; bin2 = v; end
      3:       begin st3 = 1'b1; bin3 = v; end
      default: begin st4 = 1'b1; bin4 = v; end
    endcase
    @(posedge clk); #1;
    st4 = 1'b0; st2 = 1'b0; st3 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if ((which == 2 && done2) || (which == 3 && done3) || (which == 4 && done4)) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_bcd", 32'(bcd4), 32'hAAAA);
    chk("rst_en", 32'(en4), 32'h0);
    chk("rst_ovf", 32'(ovf4), 32'h0);
    chk("rst_busy", 32'(busy4), 32'h0);
    chk("rst_done", 32'(done4), 32'h0);

    go(4, 10'd0, lat);
    chk("zero_lat", lat, 32'd11);
    chk("zero_bcd", 32'(bcd4), 32'hAAA0);
    chk("zero_en", 32'(en4), 32'hF);
    chk("zero_ovf", 32'(ovf4), 32'h0);

    // Back-to-back: each start is raised in the cycle done is high.
    go(4, 10'd1023, lat);
    chk("b2b_lat", lat, 32'd11);
`ifdef SIGNED_DISP_EN
    chk("v1023_bcd", 32'(bcd4), 32'hAAB1);
`else
    chk("v1023_bcd", 32'(bcd4), 32'h1023);
`endif
    go(4, 10'd45, lat);
    chk("v45_bcd", 32'(bcd4), 32'hAA45);
    go(4, 10'd7, lat);
    chk("v7_bcd", 32'(bcd4), 32'hAAA7);
    repeat (5) @(posedge clk);
    #1 chk("hold_bcd", 32'(bcd4), 32'hAAA7);

    // Start while busy is ignored.
    st4 = 1'b1; bin4 = 10'd45;
    ndone = 0;
    @(posedge clk); #1 st4 = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin st4 = 1'b1; bin4 = 10'd999; end
      if (k == 4) st4 = 1'b0;
      @(posedge clk); #1;
      if (k == 5) chk("ovl_busy", 32'(busy4), 32'h1);
      if (done4) ndone++;
    end
    chk("ovl_ndone", ndone, 32'd1);
    chk("ovl_bcd", 32'(bcd4), 32'hAA45);

    // Reset on the third SHIFT cycle aborts with no done.
    st4 = 1'b1; bin4 = 10'd123;
    @(posedge clk); #1 st4 = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_bcd", 32'(bcd4), 32'hAAAA);
    chk("abort_en", 32'(en4), 32'h0);
    chk("abort_busy", 32'(busy4), 32'h0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    chk("abort_ndone", ndone, 32'd0);
    go(4, 10'd9, lat);
    chk("v9_lat", lat, 32'd11);
    chk("v9_bcd", 32'(bcd4), 32'hAAA9);
    chk("v9_en", 32'(en4), 32'hF);

    // Two-digit instance: boundary and overflow.
    go(2, 10'd99, lat);
    chk("d2_99_bcd", 32'(bcd2), 32'h99);
    chk("d2_99_ovf", 32'(ovf2), 32'h0);
    go(2, 10'd100, lat);
    chk("d2_100_bcd", 32'(bcd2), 32'hBB);
    chk("d2_100_ovf", 32'(ovf2), 32'h1);
    go(2, 10'd10, lat);
    chk("d2_10_bcd", 32'(bcd2), 32'h10);
    chk("d2_10_ovf", 32'(ovf2), 32'h0);

`ifdef SIGNED_DISP_EN
    go(4, 10'h3D3, lat);
    chk("neg45_lat", lat, 32'd11);
    chk("neg45_bcd", 32'(bcd4), 32'hAB45);
    go(4, 10'h200, lat);
    chk("neg512_bcd", 32'(bcd4), 32'hB512);
    chk("neg512_ovf", 32'(ovf4), 32'h0);
    go(3, 10'h200, lat);
    chk("d3_neg512_bcd", 32'(bcd3), 32'hBBB);
    chk("d3_neg512_ovf", 32'(ovf3), 32'h1);
`else
    go(3, 10'd999, lat);
    chk("d3_999_bcd", 32'(bcd3), 32'h999);
    go(3, 10'd1000, lat);
    chk("d3_1000_bcd", 32'(bcd3), 32'hBBB);
    chk("d3_1000_ovf", 32'(ovf3), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
